// File: rtl/uart_tx_controller_if.sv
// Host/shift-register side bundle of the UART transmit controller.
// Latency: none; plain wires grouped for connection.
// Backpressure: none here; thr_full and ovr_err carry the flow status.
//
// Ports (modport slave = controller view):
//   wr_en, wr_data   host byte write strobe and data
//   ovr_clr          clears the sticky overrun flag
//   tsr_busy         shift register frame-in-progress
//   ts_load, ts_data load pulse and byte to the shift register
//   ts_shift         bit-time shift pulse to the shift register
//   thr_full, thre, temt, ovr_err  line-status outputs
interface uart_tx_controller_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       ovr_clr;
    logic       tsr_busy;
    logic       ts_load;
    logic       ts_shift;
    logic [7:0] ts_data;
    logic       thr_full;
    logic       thre;
    logic       temt;
    logic       ovr_err;

    modport master (
        output wr_en, wr_data, ovr_clr, tsr_busy,
        input  ts_load, ts_shift, ts_data, thr_full, thre, temt, ovr_err
    );

    modport slave (
        input  wr_en, wr_data, ovr_clr, tsr_busy,
        output ts_load, ts_shift, ts_data, thr_full, thre, temt, ovr_err
    );
endinterface

// File: rtl/uart_tx_controller.sv
// UART TX holding buffer + bit-timing sequencer feeding the transmit shift register.
// Latency: write in IDLE at t -> ts_load at t+1, first ts_shift at t+3; frame period 10*OVERSAMPLE+2.
// Backpressure: thr_full when buffer full; a write while full (no same-cycle pop) is dropped and sets ovr_err.
//
// Ports:
//   BCLK        clock, all logic on posedge
//   RST         synchronous active-high reset
//   bus (slave) wr_en/wr_data/ovr_clr/tsr_busy in; ts_load/ts_shift/ts_data/thr_full/thre/temt/ovr_err out
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH-deep buffer (16550 mode);
//   left undefined the buffer is a single holding register (16450 mode).
module uart_tx_controller #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16
) (
    input logic                 BCLK,
    input logic                 RST,
    uart_tx_controller_if.slave bus
);

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = FIFO_DEPTH;
`else
    localparam int DEPTH = 1;
`endif
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Storage is sized to the full pointer range so every pointer value indexes a real entry.
    localparam int MEM_N = 1 << PTR_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int DIV_W = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div;
    logic [7:0]       mem [MEM_N];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             ovr;

    logic pop;
    logic full;
    logic push;
    logic drop;

    // The head is popped in the same cycle it is presented with ts_load.
    assign pop  = (state == LOAD);
    assign full = (count == CNT_FULL);
    // A write to a full buffer still lands if the head leaves that same cycle.
    assign push = bus.wr_en && (!full || pop);
    assign drop = bus.wr_en && full && !pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        else
            return p + 1'b1;
    endfunction

    // Buffer bookkeeping and sticky overrun flag.
    always_ff @(posedge BCLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            // A drop in the same cycle as a clear must leave the flag set.
            if (drop)
                ovr <= 1'b1;
            else if (bus.ovr_clr)
                ovr <= 1'b0;
        end
    end

    // Data storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge BCLK) begin
        if (push)
            mem[wr_ptr] <= bus.wr_data;
    end

    // Sequencer. Frame length belongs to the shift register: we keep pacing
    // bit times until it drops tsr_busy, and only leave SHIFT at the end of a
    // full bit period so the stop bit is never cut short.
    always_ff @(posedge BCLK) begin
        if (RST) begin
            state <= IDLE;
            div   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0)
                        state <= LOAD;
                end
                LOAD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    div   <= '0;
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (div == DIV_MAX) begin
                        div <= '0;
                        if (!bus.tsr_busy)
                            state <= (count != '0) ? LOAD : IDLE;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    div   <= '0;
                end
            endcase
        end
    end

    assign bus.ts_load  = (state == LOAD);
    assign bus.ts_shift = (state == SHIFT) && (div == '0) && bus.tsr_busy;
    assign bus.ts_data  = mem[rd_ptr];
    assign bus.thr_full = full;
    assign bus.thre     = (count == '0);
    assign bus.temt     = (count == '0) && (state == IDLE);
    assign bus.ovr_err  = ovr;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Bench for uart_tx_controller: models a 10-bit-frame shift register on tsr_busy,
// scoreboards loaded bytes against written bytes, and checks frame timing.
// Works in both buffer builds (UART_TX_FIFO_EN defined or not).
module tb_uart_tx_controller;

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 16;
`else
    localparam int DEPTH = 1;
`endif
    localparam int OS     = 16;
    localparam int PERIOD = 10 * OS + 2;

    logic BCLK = 1'b0;
    logic RST;

    uart_tx_controller_if bus ();

    uart_tx_controller #(
        .OVERSAMPLE(OS),
        .FIFO_DEPTH(16)
    ) dut (
        .BCLK(BCLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 BCLK = ~BCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge BCLK) cyc++;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- shift-register model + scoreboard ----------------
    logic [7:0] exp_q[$];
    int         load_cyc[$];
    int         first_shift[$];
    int         last_shift_cyc   = 0;
    int         shifts_since_load = 0;
    int         load_total = 0;
    int         shift_total = 0;
    int         both_cnt = 0;
    bit         first_pending = 0;
    bit         fall_pending = 0;
    logic [7:0] last_load_dat = 8'h00;

    always @(negedge BCLK) begin
        logic s_load;
        logic s_shift;
        if (RST) begin
            bus.tsr_busy      = 1'b0;
            fall_pending      = 0;
            first_pending     = 0;
            shifts_since_load = 0;
        end else begin
            s_load  = bus.ts_load;
            s_shift = bus.ts_shift;
            if (s_load && s_shift)
                both_cnt++;
            if (fall_pending) begin
                bus.tsr_busy = 1'b0;
                fall_pending = 0;
            end
            if (s_load) begin
                load_total++;
                load_cyc.push_back(cyc);
                last_load_dat     = bus.ts_data;
                first_pending     = 1;
                shifts_since_load = 0;
                if (exp_q.size() == 0)
                    check("load_unexpected", 1, 0);
                else
                    check("load_data", bus.ts_data, exp_q.pop_front());
                bus.tsr_busy = 1'b1;
            end
            if (s_shift) begin
                shift_total++;
                shifts_since_load++;
                last_shift_cyc = cyc;
                if (first_pending) begin
                    first_shift.push_back(cyc);
                    first_pending = 0;
                end
                // Start, 8 data and stop bit: busy drops right after the 10th shift.
                if (shifts_since_load == 10)
                    fall_pending = 1;
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic write_byte(input logic [7:0] d, output int t);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(negedge BCLK);
        bus.wr_en = 1'b0;
        t = cyc;
    endtask

    task automatic wait_temt(input string name, input int limit, output int t);
        int i;
        for (i = 0; i < limit; i++) begin
            if (bus.temt)
                break;
            @(negedge BCLK);
        end
        if (i == limit)
            check(name, 0, 1);
        t = cyc;
    endtask

    task automatic wait_not_full(input string name, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (!bus.thr_full)
                break;
            @(negedge BCLK);
        end
        if (i == limit)
            check(name, 0, 1);
    endtask

    task automatic wait_new_shift(input string name, input int limit);
        int s0;
        int i;
        s0 = shift_total;
        for (i = 0; i < limit; i++) begin
            @(negedge BCLK);
            if (shift_total > s0)
                break;
        end
        if (i == limit)
            check(name, 0, 1);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] dat;
        int         load_dly;
        int         first_dly;
        int         last_dly;
        int         nshift;
        int         temt_dly;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   t, t0, te, l0, f0, s0, nq, i;
        logic [7:0] b2b [3];

        vecs[0] = '{8'hA5, 8'hA5, 1, 3, 147, 10, 163};
        vecs[1] = '{8'h00, 8'h00, 1, 3, 147, 10, 163};
        vecs[2] = '{8'hFF, 8'hFF, 1, 3, 147, 10, 163};
        vecs[3] = '{8'h5A, 8'h5A, 1, 3, 147, 10, 163};
        b2b[0] = 8'h11;
        b2b[1] = 8'h22;
        b2b[2] = 8'h33;

        RST         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovr_clr = 1'b0;

        // ---- reset ----
        repeat (2) @(posedge BCLK);
        @(negedge BCLK);
        check("rst_thre", bus.thre, 1);
        check("rst_temt", bus.temt, 1);
        check("rst_thr_full", bus.thr_full, 0);
        check("rst_ovr_err", bus.ovr_err, 0);
        check("rst_ts_load", bus.ts_load, 0);
        check("rst_ts_shift", bus.ts_shift, 0);
        RST = 1'b0;
        repeat (5) @(negedge BCLK);
        check("idle_no_pulses", load_total + shift_total, 0);

        // ---- single frames from the vector table ----
        for (int k = 0; k < 4; k++) begin
            l0 = load_total;
            exp_q.push_back(vecs[k].din);
            write_byte(vecs[k].din, t);
            wait_temt("vec_temt_timeout", 400, te);
            check("vec_load_count", load_total - l0, 1);
            check("vec_load_dly", load_cyc[$] - t, vecs[k].load_dly);
            check("vec_load_data", last_load_dat, vecs[k].dat);
            check("vec_first_shift_dly", first_shift[$] - t, vecs[k].first_dly);
            check("vec_last_shift_dly", last_shift_cyc - t, vecs[k].last_dly);
            check("vec_shift_count", shifts_since_load, vecs[k].nshift);
            check("vec_temt_dly", te - t, vecs[k].temt_dly);
            @(negedge BCLK);
        end

        // ---- three bytes back to back ----
        l0 = load_total;
        f0 = first_shift.size();
        t0 = 0;
        for (int k = 0; k < 3; k++) begin
            wait_not_full("b2b_not_full_timeout", 400);
            exp_q.push_back(b2b[k]);
            write_byte(b2b[k], t);
            if (k == 0)
                t0 = t;
        end
        wait_temt("b2b_temt_timeout", 3 * PERIOD + 400, te);
        check("b2b_load_count", load_total - l0, 3);
        check("b2b_first_shift", first_shift[f0] - t0, 3);
        check("b2b_gap_1_2", first_shift[f0 + 1] - first_shift[f0], PERIOD);
        check("b2b_gap_2_3", first_shift[f0 + 2] - first_shift[f0 + 1], PERIOD);
        @(negedge BCLK);

        // ---- fill, overrun, clear, write coincident with pop ----
        exp_q.push_back(8'h01);
        write_byte(8'h01, t);
        wait_new_shift("fill_first_shift_timeout", 50);
        for (i = 0; i < DEPTH; i++) begin
            exp_q.push_back(8'h40 + 8'(i));
            write_byte(8'h40 + 8'(i), t);
        end
        check("fill_thr_full", bus.thr_full, 1);
        check("fill_thre", bus.thre, 0);
        check("fill_ovr_before", bus.ovr_err, 0);
        write_byte(8'hFF, t);
        check("ovr_set", bus.ovr_err, 1);
        check("ovr_still_full", bus.thr_full, 1);
        bus.ovr_clr = 1'b1;
        @(negedge BCLK);
        bus.ovr_clr = 1'b0;
        check("ovr_cleared", bus.ovr_err, 0);
        bus.ovr_clr = 1'b1;
        write_byte(8'hEE, t);
        bus.ovr_clr = 1'b0;
        check("ovr_set_beats_clr", bus.ovr_err, 1);
        bus.ovr_clr = 1'b1;
        @(negedge BCLK);
        bus.ovr_clr = 1'b0;
        check("ovr_cleared_again", bus.ovr_err, 0);
        for (i = 0; i < 400; i++) begin
            if (bus.ts_load)
                break;
            @(negedge BCLK);
        end
        if (i == 400)
            check("fill_load_timeout", 0, 1);
        exp_q.push_back(8'hC3);
        write_byte(8'hC3, t);
        check("pop_push_thr_full", bus.thr_full, 1);
        check("pop_push_no_ovr", bus.ovr_err, 0);
        wait_temt("fill_drain_timeout", (DEPTH + 3) * PERIOD + 400, te);
        check("fill_all_loaded", exp_q.size(), 0);
        @(negedge BCLK);

        // ---- reset in the middle of a frame with bytes queued ----
        nq = (DEPTH >= 3) ? 3 : DEPTH;
        exp_q.push_back(8'h77);
        write_byte(8'h77, t);
        wait_new_shift("mid_first_shift_timeout", 50);
        for (i = 0; i < nq; i++) begin
            exp_q.push_back(8'h90 + 8'(i));
            write_byte(8'h90 + 8'(i), t);
        end
        for (i = 0; i < 200; i++) begin
            if (shifts_since_load >= 5)
                break;
            @(negedge BCLK);
        end
        if (i == 200)
            check("mid_fifth_shift_timeout", 0, 1);
        RST = 1'b1;
        @(negedge BCLK);
        check("mid_rst_thre", bus.thre, 1);
        check("mid_rst_temt", bus.temt, 1);
        check("mid_rst_thr_full", bus.thr_full, 0);
        check("mid_rst_ts_load", bus.ts_load, 0);
        check("mid_rst_ts_shift", bus.ts_shift, 0);
        @(negedge BCLK);
        RST = 1'b0;
        exp_q.delete();
        l0 = load_total;
        s0 = shift_total;
        repeat (400) @(negedge BCLK);
        check("mid_rst_no_load_after", load_total - l0, 0);
        check("mid_rst_no_shift_after", shift_total - s0, 0);
        check("mid_rst_still_empty", bus.thre, 1);

        check("load_shift_overlap", both_cnt, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
